pattern_sweep_gen: RTL and testbench

- Upstream stimulus stage for the 6-input De Morgan logic block on the board.
- Steps a 6-bit vector through 0..63 at a prescaled rate; each bit drives one logic input (vec[5]=a ... vec[0]=f).
- Sweep is started and stopped by push-buttons, so a full truth table can be walked on hardware without a bench.
- Supports single-sweep and continuous modes.

---
 rtl/sweep_pkg.sv | 13 +
 rtl/sync_edge.sv | 34 +++
 rtl/pattern_sweep_gen.sv | 120 ++++++++++++
 tb/tb_pattern_sweep_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared constants for the pattern sweep generator: FSM state encoding and
// the default vector width.
package sweep_pkg;

    localparam int SWEEP_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// rising-edge detector producing a single-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    // Combinational from stage 2 so the FSM reacts on the third clock edge.
    assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/pattern_sweep_gen.sv
// Button-controlled 0..2^WIDTH-1 pattern sweeper with prescaled step rate.
// Define SWEEP_STEP_EN to add the manual single-step 'adv' button.
module pattern_sweep_gen
    import sweep_pkg::*;
#(
    parameter int DIV   = 12000000,
    parameter int WIDTH = SWEEP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef SWEEP_STEP_EN
    input  logic             adv,
`endif
    input  logic             mode_cont,
    output logic [WIDTH-1:0] vec,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int             PW       = $clog2(DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] VEC_MAX = '1;

    logic start_p, stop_p;

    sync_edge u_start_sync (.clk(clk), .rst(rst), .din(start), .pulse(start_p));
    sync_edge u_stop_sync  (.clk(clk), .rst(rst), .din(stop),  .pulse(stop_p));

`ifdef SWEEP_STEP_EN
    logic adv_p;
    sync_edge u_adv_sync   (.clk(clk), .rst(rst), .din(adv),   .pulse(adv_p));
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q,   vec_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             step_q,  step_d;
    logic             mode_q,  mode_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        presc_d = presc_q;
        step_d  = 1'b0;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop_p) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (start_p) begin
                    state_d = ST_RUN;
                    vec_d   = '0;
                    presc_d = '0;
                    mode_d  = mode_cont;
                    step_d  = 1'b1;
                end
`ifdef SWEEP_STEP_EN
                else if (adv_p) begin
                    state_d = ST_IDLE;
                    vec_d   = vec_q + 1'b1;
                    step_d  = 1'b1;
                end
`endif
            end

            ST_RUN: begin
                // Stop outranks a terminal count landing in the same cycle.
                if (stop_p) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    if (vec_q != VEC_MAX) begin
                        vec_d  = vec_q + 1'b1;
                        step_d = 1'b1;
                    end else if (mode_q) begin
                        vec_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            presc_q <= '0;
            step_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    assign vec  = vec_q;
    assign step = step_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Scoreboard bench for pattern_sweep_gen with DIV=4: stimulus queues the
// expected vec value of every step pulse, a monitor pops and compares.
module tb_pattern_sweep_gen;

    localparam int DIV   = 4;
    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
`ifdef SWEEP_STEP_EN
    logic             adv = 1'b0;
`endif
    logic             mode_cont = 1'b0;
    logic [WIDTH-1:0] vec;
    logic             step;
    logic             busy;
    logic             done;

    pattern_sweep_gen #(.DIV(DIV), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
`ifdef SWEEP_STEP_EN
        .adv      (adv),
`endif
        .mode_cont(mode_cont),
        .vec      (vec),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles = 0;
    int step_count  = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(WIDTH'(i));
    endtask

    // Monitor: pops the scoreboard on each step, checks hold time and spacing.
    initial begin : monitor
        logic [WIDTH-1:0] e;
        bit prev_step = 1'b0;
        bit in_run    = 1'b0;
        int gap       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_step = 1'b0;
                in_run    = 1'b0;
                gap       = 0;
            end else begin
                gap++;
                if (busy) busy_cycles++;
                if (!busy) in_run = 1'b0;
                if (step) begin
                    step_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_step", 32'(vec), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("step_vec", 32'(vec), 32'(e));
                        $display("step %0d: vec=%0d busy=%0d", step_count, vec, busy);
                    end
                    if (in_run) check("hold_cycles", gap, DIV);
                    check("step_not_back_to_back", 32'(prev_step), 0);
                    in_run = busy;
                    gap    = 0;
                end
                prev_step = step;
            end
        end
    end

    // Inputs are set at the current negedge; the FSM reacts on the 3rd edge.
    task automatic press(input bit s, input bit p);
        start = s;
        stop  = p;
        repeat (4) @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef SWEEP_STEP_EN
    task automatic press_adv();
        adv = 1'b1;
        repeat (4) @(negedge clk);
        adv = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic wait_step_vec(input int v, input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (step && vec == WIDTH'(v)) hit = 1'b1;
        end
        check(name, 32'(hit), 1);
    endtask

    task automatic wait_done(input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
        check(name, 32'(hit), 1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_vec", 32'(vec), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_step", 32'(step), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single sweep; mode flipped after start must not matter
        push_range(0, 63);
        busy_cycles = 0;
        mode_cont = 1'b0;
        press(1'b1, 1'b0);
        mode_cont = 1'b1;
        wait_done(400, "single_reaches_done");
        #1;
        check("single_busy_cycles", busy_cycles, 256);
        check("single_vec_max", 32'(vec), 63);
        check("single_busy_low", 32'(busy), 0);
        check("single_done_high", 32'(done), 1);
        check("single_queue_empty", exp_q.size(), 0);
        @(negedge clk);

        // Restart from DONE, stop at vec=10
        push_range(0, 10);
        mode_cont = 1'b0;
        press(1'b1, 1'b0);
        wait_step_vec(10, 100, "reach_vec10");
        press(1'b0, 1'b1);
        #1;
        check("stop_busy", 32'(busy), 0);
        check("stop_done", 32'(done), 0);
        check("stop_vec_held", 32'(vec), 10);
        @(negedge clk);

        // Start and stop together in IDLE: nothing happens
        press(1'b1, 1'b1);
        #1;
        check("both_idle_busy", 32'(busy), 0);
        check("both_idle_vec", 32'(vec), 10);
        @(negedge clk);

        // Continuous mode wraps 63 -> 0
        push_range(0, 63);
        push_range(0, 2);
        mode_cont = 1'b1;
        press(1'b1, 1'b0);
        mode_cont = 1'b0;
        wait_step_vec(63, 400, "cont_reach_63");
        wait_step_vec(2, 40, "cont_wrap_to_2");
        #1;
        check("cont_busy", 32'(busy), 1);
        check("cont_done", 32'(done), 0);
        @(negedge clk);
        // Start and stop together in RUN: stop wins (one more step lands first)
        push_range(3, 3);
        wait_step_vec(3, 20, "cont_align_3");
        press(1'b1, 1'b1);
        #1;
        check("both_run_busy", 32'(busy), 0);
        check("both_run_vec", 32'(vec), 3);
        @(negedge clk);

        // Asynchronous reset mid-sweep at vec=37
        push_range(0, 37);
        press(1'b1, 1'b0);
        wait_step_vec(37, 400, "reach_vec37");
        #2 rst = 1'b1;
        #1;
        check("async_rst_vec", 32'(vec), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_step", 32'(step), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_vec", 32'(vec), 0);

`ifdef SWEEP_STEP_EN
        // Manual stepping from IDLE
        push_range(1, 3);
        for (int i = 0; i < 3; i++) press_adv();
        check("adv_vec3", 32'(vec), 3);
        check("adv_busy", 32'(busy), 0);
        // adv from DONE at vec=63 wraps to 0 and clears done
        push_range(0, 63);
        mode_cont = 1'b0;
        press(1'b1, 1'b0);
        wait_done(400, "adv_sweep_done");
        @(negedge clk);
        push_range(0, 0);
        press_adv();
        check("adv_wrap_vec", 32'(vec), 0);
        check("adv_wrap_done", 32'(done), 0);
        // adv during RUN is ignored; the scoreboard catches any disturbance
        push_range(0, 5);
        press(1'b1, 1'b0);
        wait_step_vec(1, 20, "adv_run_align");
        press_adv();
        wait_step_vec(5, 40, "adv_run_reach5");
        press(1'b0, 1'b1);
        check("adv_run_vec", 32'(vec), 5);
        check("adv_run_busy", 32'(busy), 0);
`endif

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
